rx_fifo: RTL and testbench
==========================

RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 SHALL provide port: clk  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL provide port: n_rst  in  1  reset, synchronous, active-high (n_rst=1 at a clk edge resets).
REQ-003 SHALL provide port: rx_data  in  8  received byte from the UART receive block.
REQ-004 SHALL provide port: data_ready  in  1  receive block holds a valid byte.
REQ-005 SHALL provide port: overrun_error  in  1  receive block overrun indication.
REQ-006 SHALL provide port: framing_error  in  1  receive block framing indication for the current byte.
REQ-007 SHALL provide port: data_read  out  1  one-cycle acknowledge to the receive block.
REQ-008 SHALL provide port: pop  in  1  consumer read strobe.
REQ-009 SHALL provide port: rd_data  out  8  head entry (show-ahead).
REQ-010 SHALL provide port: rd_err  out  1  framing tag of head entry.
REQ-011 SHALL provide port: fifo_empty  out  1 / fifo_full  out  1 / fifo_count  out  5  occupancy 0..16.
REQ-012 SHALL provide port: clear_err  in  1 / ovr_seen  out  1 / frm_seen  out  1  sticky error flags and their clear.

Function
REQ-013 SHALL store bytes in a 16-entry memory; 4-bit write/read pointers wrap 15->0.
REQ-014 SHALL run a capture FSM with states IDLE, CAPTURE, WAIT.
REQ-015 IDLE->CAPTURE when data_ready=1 and fifo_full=0; otherwise SHALL remain in IDLE without writing.
REQ-016 In CAPTURE SHALL write rx_data at wptr, advance wptr, assert data_read=1 for exactly that cycle, then go to WAIT.
REQ-017 WAIT->IDLE when data_ready=0; data_read SHALL be 0 in IDLE and WAIT.
REQ-018 Latency: byte SHALL be visible on rd_data 2 cycles after data_ready rises into an empty FIFO.
REQ-019 rd_data SHALL equal mem[rptr] combinationally; when empty, rd_data holds the last-written value at rptr (don't care).
REQ-020 pop=1 with fifo_empty=0 SHALL advance rptr; pop while empty SHALL be ignored.
REQ-021 Simultaneous CAPTURE write and valid pop SHALL leave fifo_count unchanged, both pointers advance.
REQ-022 Full FIFO SHALL stall capture; the receive block then sees no data_read and flags its own overrun; no FIFO entry is overwritten.
REQ-023 fifo_empty = (count==0), fifo_full = (count==16); both SHALL derive from a registered count.
REQ-024 ovr_seen SHALL set the cycle after overrun_error=1; frm_seen SHALL set the cycle after a CAPTURE with framing_error=1; both held until clear_err=1.
REQ-025 clear_err and a same-cycle set event: set SHALL win.

Reset
REQ-026 On reset: FSM=IDLE, pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, data_read=0, ovr_seen=0, frm_seen=0, rd_err=0.
REQ-027 Reset asserted during CAPTURE or WAIT SHALL abort with no write and no data_read pulse; memory contents need not be cleared.

Configuration
REQ-028 Macro RX_FIFO_ERR_TAG_EN defined: each entry SHALL be 9 bits, storing framing_error at capture; rd_err = tag of head entry.
REQ-029 Macro RX_FIFO_ERR_TAG_EN undefined: entries SHALL be 8 bits; rd_err SHALL be constant 0; frm_seen unaffected.

Verification
REQ-030 Reset, then data_ready=1 with rx_data=8'hA5 -> data_read pulses 1 cycle; 2 cycles later rd_data=8'hA5, fifo_count=1, fifo_empty=0.
REQ-031 Write 16 bytes 8'h00..8'h0F, 17th data_ready held -> fifo_full=1, no data_read; pop once -> 17th captured, count stays 16; pops return 8'h01..8'h0F, then 17th byte in order.
REQ-032 Write 20 bytes interleaved with pops (pointer wrap) -> output order matches input order, count never exceeds 16.
REQ-033 Byte 8'h3C with framing_error=1 -> frm_seen=1 next cycle; with RX_FIFO_ERR_TAG_EN rd_err=1 at that entry, without it rd_err=0; clear_err -> frm_seen=0.
REQ-034 pop on empty FIFO -> count stays 0, rptr unchanged; same-cycle capture+pop at count=5 -> count stays 5.
REQ-035 Assert n_rst in the CAPTURE cycle -> no data_read pulse, count=0, FSM=IDLE next cycle.

Source files
------------

// File: rtl/rx_fifo.sv
// Receive FIFO between a UART receive block and a consumer: 16-entry show-ahead
// buffer with capture handshake and sticky error flags. Optional define RX_FIFO_ERR_TAG_EN.
module rx_fifo (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       data_ready,
  input  logic       overrun_error,
  input  logic       framing_error,
  output logic       data_read,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       rd_err,
  output logic       fifo_empty,
  output logic       fifo_full,
  output logic [4:0] fifo_count,
  input  logic       clear_err,
  output logic       ovr_seen,
  output logic       frm_seen
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned CW    = 5;
`ifdef RX_FIFO_ERR_TAG_EN
  localparam int unsigned EW    = 9;
`else
  localparam int unsigned EW    = 8;
`endif

  typedef enum logic [1:0] {IDLE, CAPTURE, WAIT} state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            wr_en;
  logic            rd_en;
  logic [EW-1:0]   wr_entry;
  logic [EW-1:0]   head;

  assign wr_en      = (state == CAPTURE);
  assign rd_en      = pop && !fifo_empty;
  assign fifo_count = count;
  assign fifo_empty = (count == CW'(0));
  assign fifo_full  = (count == CW'(DEPTH));
  assign head       = mem[rptr];

  // A reset landing in the capture cycle withdraws the acknowledge immediately
  assign data_read  = wr_en && !n_rst;

`ifdef RX_FIFO_ERR_TAG_EN
  assign wr_entry = {framing_error, rx_data};
  assign rd_data  = head[7:0];
  assign rd_err   = !fifo_empty && head[8];
`else
  assign wr_entry = rx_data;
  assign rd_data  = head;
  assign rd_err   = 1'b0;
`endif

  // Capture FSM, pointers, occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      ovr_seen <= 1'b0;
      frm_seen <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (data_ready && !fifo_full) state <= CAPTURE;
        CAPTURE: state <= WAIT;
        WAIT:    if (!data_ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);

      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Set events take priority over clear
      if (overrun_error)                ovr_seen <= 1'b1;
      else if (clear_err)               ovr_seen <= 1'b0;

      if (wr_en && framing_error)       frm_seen <= 1'b1;
      else if (clear_err)               frm_seen <= 1'b0;
    end
  end

  // Storage is not reset; a reset in the capture cycle suppresses the write
  always_ff @(posedge clk) begin
    if (wr_en && !n_rst) mem[wptr] <= wr_entry;
  end

endmodule

// File: tb/tb_rx_fifo.sv
// Self-checking bench for rx_fifo: vector table plus scoreboard of captured bytes.
module tb_rx_fifo;

  logic       clk;
  logic       n_rst;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       data_read;
  logic       pop;
  logic [7:0] rd_data;
  logic       rd_err;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       clear_err;
  logic       ovr_seen;
  logic       frm_seen;

  rx_fifo dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .data_read     (data_read),
    .pop           (pop),
    .rd_data       (rd_data),
    .rd_err        (rd_err),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .clear_err     (clear_err),
    .ovr_seen      (ovr_seen),
    .frm_seen      (frm_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } sb_t;

  typedef struct {
    logic [7:0] d;
    logic       do_pop;
    logic [4:0] exp_count;
  } vec_t;

  sb_t  sb[$];
  vec_t vt[20];
  int   n_vec = 0;
  int   n_mis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic e);
`ifdef RX_FIFO_ERR_TAG_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    pop = 1'b0; data_ready = 1'b0; clear_err = 1'b0;
    overrun_error = 1'b0; framing_error = 1'b0;
    n_rst = 1'b1;
    tick; tick;
    n_rst = 1'b0;
    sb.delete();
  endtask

  // Wait for the acknowledge, record the byte, then finish the handshake
  task automatic finish_write(input logic [7:0] d, input logic e);
    int k = 0;
    while (!data_read && k < 40) begin
      tick;
      k++;
    end
    chk("ack_seen", 32'(data_read), 32'(1));
    if (data_read) sb.push_back(sb_t'{d, e});
    tick;
    chk("ack_one_cycle", 32'(data_read), 32'(0));
    if (e) chk("frm_set", 32'(frm_seen), 32'(1));
    data_ready = 1'b0;
    tick;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic e);
    rx_data = d;
    framing_error = e;
    data_ready = 1'b1;
    finish_write(d, e);
    framing_error = 1'b0;
  endtask

  task automatic pop_check;
    sb_t x;
    if (sb.size() == 0) begin
      chk("sb_has_entry", 32'(sb.size()), 32'(1));
    end else begin
      x = sb.pop_front();
      chk("not_empty", 32'(fifo_empty), 32'(0));
      chk("rd_data", 32'(rd_data), 32'(x.d));
      chk("rd_err", 32'(rd_err), 32'(exp_err(x.e)));
      pop = 1'b1;
      tick;
      pop = 1'b0;
    end
  endtask

  task automatic drain;
    int k = 0;
    while (sb.size() > 0 && k < 40) begin
      pop_check;
      k++;
    end
    chk("drained_empty", 32'(fifo_empty), 32'(1));
    chk("drained_count", 32'(fifo_count), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sb_t x;
    int  k;

    for (int i = 0; i < 20; i++) begin
      vt[i].d         = 8'(8'hC0 + i * 3);
      vt[i].do_pop    = (i % 4 == 3);
      vt[i].exp_count = 5'((i + 1) - (i + 1) / 4);
    end

    rx_data = 8'h00;
    do_reset;

    // Reset state
    chk("rst_empty", 32'(fifo_empty), 32'(1));
    chk("rst_full", 32'(fifo_full), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_data_read", 32'(data_read), 32'(0));
    chk("rst_ovr", 32'(ovr_seen), 32'(0));
    chk("rst_frm", 32'(frm_seen), 32'(0));
    chk("rst_rd_err", 32'(rd_err), 32'(0));

    // First byte latency
    rx_data = 8'hA5;
    data_ready = 1'b1;
    tick;
    chk("a5_ack", 32'(data_read), 32'(1));
    tick;
    chk("a5_ack_drop", 32'(data_read), 32'(0));
    chk("a5_rd_data", 32'(rd_data), 32'(8'hA5));
    chk("a5_count", 32'(fifo_count), 32'(1));
    chk("a5_empty", 32'(fifo_empty), 32'(0));
    data_ready = 1'b0;
    tick;
    sb.push_back(sb_t'{8'hA5, 1'b0});
    drain;

    // Fill to full, stall the 17th byte, then release it with one pop
    do_reset;
    for (int i = 0; i < 16; i++) write_byte(8'(i), 1'b0);
    chk("full_flag", 32'(fifo_full), 32'(1));
    chk("full_count", 32'(fifo_count), 32'(16));
    rx_data = 8'h55;
    data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_no_ack", 32'(data_read), 32'(0));
    end
    chk("stall_count", 32'(fifo_count), 32'(16));
    pop_check;
    finish_write(8'h55, 1'b0);
    chk("refill_count", 32'(fifo_count), 32'(16));
    drain;

    // Table: 20 writes with interleaved pops, pointers wrap
    for (int i = 0; i < 20; i++) begin
      write_byte(vt[i].d, 1'b0);
      if (vt[i].do_pop) pop_check;
      chk("tbl_count", 32'(fifo_count), 32'(vt[i].exp_count));
      chk("tbl_bound", 32'(fifo_count <= 5'd16), 32'(1));
    end
    drain;

    // Framing tag and sticky flags
    do_reset;
    write_byte(8'h3C, 1'b1);
    pop_check;
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    chk("frm_clear", 32'(frm_seen), 32'(0));
    overrun_error = 1'b1;
    tick;
    chk("ovr_set", 32'(ovr_seen), 32'(1));
    clear_err = 1'b1;
    tick;
    chk("ovr_set_wins", 32'(ovr_seen), 32'(1));
    overrun_error = 1'b0;
    tick;
    chk("ovr_clear", 32'(ovr_seen), 32'(0));
    clear_err = 1'b0;

    // Pop on empty is ignored
    do_reset;
    pop = 1'b1;
    tick;
    pop = 1'b0;
    chk("empty_pop_count", 32'(fifo_count), 32'(0));
    chk("empty_pop_empty", 32'(fifo_empty), 32'(1));
    write_byte(8'h9E, 1'b0);
    pop_check;

    // Simultaneous capture and pop at count 5
    do_reset;
    for (int i = 0; i < 5; i++) write_byte(8'(8'h10 + i), 1'b0);
    chk("pre_sim_count", 32'(fifo_count), 32'(5));
    rx_data = 8'h77;
    data_ready = 1'b1;
    k = 0;
    while (!data_read && k < 40) begin
      tick;
      k++;
    end
    chk("sim_ack", 32'(data_read), 32'(1));
    x = sb.pop_front();
    chk("sim_rd_data", 32'(rd_data), 32'(x.d));
    sb.push_back(sb_t'{8'h77, 1'b0});
    pop = 1'b1;
    tick;
    pop = 1'b0;
    chk("sim_count", 32'(fifo_count), 32'(5));
    data_ready = 1'b0;
    tick;
    drain;

    // Reset during the capture cycle
    do_reset;
    rx_data = 8'hEE;
    data_ready = 1'b1;
    tick;
    n_rst = 1'b1;
    #1;
    chk("rst_cap_no_ack", 32'(data_read), 32'(0));
    tick;
    chk("rst_cap_count", 32'(fifo_count), 32'(0));
    chk("rst_cap_empty", 32'(fifo_empty), 32'(1));
    chk("rst_cap_idle_ack", 32'(data_read), 32'(0));
    n_rst = 1'b0;
    data_ready = 1'b0;
    tick;
    chk("rst_cap_after", 32'(fifo_count), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
